// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared encodings for the HI/LO multiply/divide sequencer
package hilo_muldiv_ctrl_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MD_CNT_W = cnt_width(MD_WIDTH);

  function automatic logic op_is_div(input logic [1:0] o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_muldiv_step.sv
// rtl/hilo_muldiv_ctrl_muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    shifted = {acc, q[WIDTH-1]};
    // Remainder stays below the divisor, so bit WIDTH of diff is a clean borrow flag.
    diff    = shifted - {1'b0, b};
    if (!div) begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_nxt = diff[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = shifted[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO write port
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             hiloWrite,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          state;
  logic [CW-1:0]      counter;
  logic               is_div_r;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   q_nxt;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div     (is_div_r),
    .acc     (acc),
    .q       (q),
    .b       (b),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  always_comb begin
    a_neg    = op_is_signed(op) & srcA[WIDTH-1];
    b_neg    = op_is_signed(op) & srcB[WIDTH-1];
    abs_a    = a_neg ? (~srcA + 1'b1) : srcA;
    abs_b    = b_neg ? (~srcB + 1'b1) : srcB;
    // Sign fixup is applied to the final step's combinational result so that
    // HI/LO are registered on the same edge that enters DONE.
    prod     = {acc_nxt, q_nxt};
    prod_fix = neg_res ? (~prod + 1'b1) : prod;
    quo_fix  = neg_res ? (~q_nxt + 1'b1) : q_nxt;
    rem_fix  = neg_rem ? (~acc_nxt + 1'b1) : acc_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      counter   <= '0;
      is_div_r  <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      acc       <= '0;
      q         <= '0;
      b         <= '0;
      busy      <= 1'b0;
      hiloWrite <= 1'b0;
      hiOut     <= '0;
      loOut     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          hiloWrite <= 1'b0;
          if (start) begin
            is_div_r <= op_is_div(op);
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            acc      <= '0;
            q        <= abs_a;
            b        <= abs_b;
            counter  <= '0;
            busy     <= 1'b1;
            if (op_is_div(op) && (srcB == '0)) begin
              hiOut     <= srcA;
              loOut     <= '1;
              hiloWrite <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc     <= acc_nxt;
          q       <= q_nxt;
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            state     <= ST_DONE;
            hiloWrite <= 1'b1;
            if (is_div_r) begin
              hiOut <= rem_fix;
              loOut <= quo_fix;
            end else begin
              {hiOut, loOut} <= prod_fix;
            end
          end
        end
        ST_DONE: begin
          hiloWrite <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          hiloWrite <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] srcA  = '0;
  logic [31:0] srcB  = '0;
  logic        busy;
  logic        hiloWrite;
  logic [31:0] hiOut;
  logic [31:0] loOut;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .busy      (busy),
    .hiloWrite (hiloWrite),
    .hiOut     (hiOut),
    .loOut     (loOut)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference results straight from integer arithmetic semantics.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: return ua * ub;
      2'b01: return 64'(sa * sb);
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
    endcase
  endfunction

  // Launch one op and watch a fixed 40-cycle window after the accepting edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit disturb,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output int busy_cyc, output int pulses);
    lat = 0; busy_cyc = 0; pulses = 0; hi = 'x; lo = 'x;
    @(negedge CLK);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(negedge CLK);
    start = hold;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cyc++;
      if (hiloWrite) begin
        pulses++;
        if (lat == 0) begin
          lat = c; hi = hiOut; lo = loOut;
        end
        start = 1'b0;
      end
      if (disturb && c == 5) begin
        srcA = ~a; srcB = b ^ 32'h5A5A_0001; op = ~o;
      end
      if (disturb && c == 10) start = 1'b1;
      if (disturb && c == 11) start = 1'b0;
      @(negedge CLK);
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input bit hold, input bit disturb);
    logic [31:0] hi, lo;
    int lat, bc, pc, elat;
    run_op(o, a, b, hold, disturb, hi, lo, lat, bc, pc);
    elat = (o[1] && b == 0) ? 1 : 33;
    chk({tag, ".hi"}, 64'(hi), 64'(ehi));
    chk({tag, ".lo"}, 64'(lo), 64'(elo));
    chk({tag, ".lat"}, 64'(lat), 64'(elat));
    chk({tag, ".busy_cycles"}, 64'(bc), 64'(elat));
    chk({tag, ".pulses"}, 64'(pc), 64'd1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] m;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    int pulses;

    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE});
    vecs.push_back('{2'b01, 32'hFFFF_FFFB, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{2'b10, 32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000});
    vecs.push_back('{2'b00, 32'h0,         32'h0001_2345, 32'h0,         32'h0});
    vecs.push_back('{2'b10, 32'd5,         32'h0,         32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0});
    vecs.push_back('{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1});

    #12;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.hiloWrite", 64'(hiloWrite), 64'd0);
    chk("reset.hi", 64'(hiOut), 64'd0);
    chk("reset.lo", 64'(loOut), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 1'b0);

    check_op("hold_start", 2'b01, 32'hFFFF_FFFB, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0);
    check_op("mid_start_toggle", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick_val();
      rb = pick_val();
      m  = ref_model(ro, ra, rb);
      check_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, m[63:32], m[31:0], 1'b0, 1'b0);
    end

    // Abort at counter==10 (cycle 11 after the accepting edge).
    @(negedge CLK);
    op = 2'b00; srcA = 32'hDEAD_BEEF; srcB = 32'h0000_1234; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.hiloWrite", 64'(hiloWrite), 64'd0);
    chk("abort.hi", 64'(hiOut), 64'd0);
    chk("abort.lo", 64'(loOut), 64'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (c == 2) RST_N = 1'b1;
      if (hiloWrite) pulses++;
    end
    chk("abort.no_pulse", 64'(pulses), 64'd0);
    m = ref_model(2'b00, 32'hDEAD_BEEF, 32'h0000_1234);
    check_op("after_abort", 2'b00, 32'hDEAD_BEEF, 32'h0000_1234, m[63:32], m[31:0], 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
